// File: rtl/bgpu_jtag_dmi_responder.sv
// rtl/bgpu_jtag_dmi_responder.sv - oversampled JTAG TAP plus RISC-V DTM issuing valid/ready DMI transactions
// Optional response timeout in WAIT: define BGPU_JTAG_DMI_TIMEOUT_EN.
module bgpu_jtag_dmi_responder #(
  parameter logic [31:0] IdCode        = 32'h00000DB3,
  parameter int          IrLength      = 5,
  parameter int          DmiAddrWidth  = 7,
  parameter int          SyncStages    = 2,
  parameter int          TimeoutCycles = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    jtag_tck_i,
  input  logic                    jtag_tms_i,
  input  logic                    jtag_tdi_i,
  input  logic                    jtag_trst_ni,
  output logic                    jtag_tdo_o,
  output logic                    dmi_req_valid_o,
  input  logic                    dmi_req_ready_i,
  output logic [DmiAddrWidth-1:0] dmi_req_addr_o,
  output logic [1:0]              dmi_req_op_o,
  output logic [31:0]             dmi_req_data_o,
  input  logic                    dmi_resp_valid_i,
  output logic                    dmi_resp_ready_o,
  input  logic [31:0]             dmi_resp_data_i,
  input  logic [1:0]              dmi_resp_err_i
);
  localparam int DrWidth = DmiAddrWidth + 34;
  localparam logic [IrLength-1:0] IrIdcode = IrLength'(5'h01);
  localparam logic [IrLength-1:0] IrDtmcs  = IrLength'(5'h10);
  localparam logic [IrLength-1:0] IrDmi    = IrLength'(5'h11);

  typedef enum logic [3:0] {
    TapReset, TapIdle, TapSelDr, TapCapDr, TapShDr, TapEx1Dr, TapPauDr, TapEx2Dr,
    TapUpdDr, TapSelIr, TapCapIr, TapShIr, TapEx1Ir, TapPauIr, TapEx2Ir, TapUpdIr
  } tap_state_e;
  typedef enum logic [1:0] {DmiIdle, DmiReq, DmiWait} dmi_state_e;
  typedef enum logic [1:0] {SelBypass, SelIdcode, SelDtmcs, SelDmi} dr_sel_e;

  logic [SyncStages-1:0] tck_sync, tms_sync, tdi_sync, trst_sync;
  logic tck_q, tck_s, tms_s, tdi_s, trst_s, tck_rise, tck_fall;
  tap_state_e tap_q, tap_d;
  logic capture_ir, shift_ir, update_ir, capture_dr, shift_dr, update_dr;
  logic [IrLength-1:0] ir_q, ir_shift_q;
  dr_sel_e dr_sel;
  logic [DrWidth-1:0] dr_q;
  dmi_state_e dmi_q, dmi_d;
  logic drain_q, timeout;
  logic [1:0] sticky_q, status_view;
  logic [DmiAddrWidth-1:0] last_addr_q;
  logic [31:0] last_rdata_q, rdata_view;
  logic [1:0] dr_op;
  logic dmi_op_valid, resp_take, pending, req_accept, req_busy, dtmcs_update, hard_reset, err_clear;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tck_sync  <= '0;
      tms_sync  <= '0;
      tdi_sync  <= '0;
      trst_sync <= '0;
      tck_q     <= 1'b0;
    end else begin
      tck_sync  <= {tck_sync[SyncStages-2:0], jtag_tck_i};
      tms_sync  <= {tms_sync[SyncStages-2:0], jtag_tms_i};
      tdi_sync  <= {tdi_sync[SyncStages-2:0], jtag_tdi_i};
      trst_sync <= {trst_sync[SyncStages-2:0], jtag_trst_ni};
      tck_q     <= tck_s;
    end
  end

  assign tck_s    = tck_sync[SyncStages-1];
  assign tms_s    = tms_sync[SyncStages-1];
  assign tdi_s    = tdi_sync[SyncStages-1];
  assign trst_s   = trst_sync[SyncStages-1];
  assign tck_rise = tck_s & ~tck_q;
  assign tck_fall = ~tck_s & tck_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) tap_q <= TapReset;
    else       tap_q <= tap_d;
  end

  always_comb begin
    tap_d = tap_q;
    if (!trst_s) begin
      tap_d = TapReset;
    end else if (tck_rise) begin
      case (tap_q)
        TapReset: tap_d = tms_s ? TapReset : TapIdle;
        TapIdle:  tap_d = tms_s ? TapSelDr : TapIdle;
        TapSelDr: tap_d = tms_s ? TapSelIr : TapCapDr;
        TapCapDr: tap_d = tms_s ? TapEx1Dr : TapShDr;
        TapShDr:  tap_d = tms_s ? TapEx1Dr : TapShDr;
        TapEx1Dr: tap_d = tms_s ? TapUpdDr : TapPauDr;
        TapPauDr: tap_d = tms_s ? TapEx2Dr : TapPauDr;
        TapEx2Dr: tap_d = tms_s ? TapUpdDr : TapShDr;
        TapUpdDr: tap_d = tms_s ? TapSelDr : TapIdle;
        TapSelIr: tap_d = tms_s ? TapReset : TapCapIr;
        TapCapIr: tap_d = tms_s ? TapEx1Ir : TapShIr;
        TapShIr:  tap_d = tms_s ? TapEx1Ir : TapShIr;
        TapEx1Ir: tap_d = tms_s ? TapUpdIr : TapPauIr;
        TapPauIr: tap_d = tms_s ? TapEx2Ir : TapPauIr;
        TapEx2Ir: tap_d = tms_s ? TapUpdIr : TapShIr;
        TapUpdIr: tap_d = tms_s ? TapSelDr : TapIdle;
      endcase
    end
  end

  // Capture/shift/update act on the rise that leaves the corresponding state.
  always_comb begin
    capture_ir = 1'b0;
    shift_ir   = 1'b0;
    update_ir  = 1'b0;
    capture_dr = 1'b0;
    shift_dr   = 1'b0;
    update_dr  = 1'b0;
    if (tck_rise && trst_s) begin
      capture_ir = (tap_q == TapCapIr);
      shift_ir   = (tap_q == TapShIr);
      update_ir  = (tap_q == TapUpdIr);
      capture_dr = (tap_q == TapCapDr);
      shift_dr   = (tap_q == TapShDr);
      update_dr  = (tap_q == TapUpdDr);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ir_q       <= IrIdcode;
      ir_shift_q <= '0;
    end else begin
      if (tap_q == TapReset) ir_q <= IrIdcode;
      else if (update_ir)    ir_q <= ir_shift_q;
      if (capture_ir)        ir_shift_q <= IrLength'(1);
      else if (shift_ir)     ir_shift_q <= {tdi_s, ir_shift_q[IrLength-1:1]};
    end
  end

  always_comb begin
    dr_sel = SelBypass;
    if (ir_q == IrIdcode)     dr_sel = SelIdcode;
    else if (ir_q == IrDtmcs) dr_sel = SelDtmcs;
    else if (ir_q == IrDmi)   dr_sel = SelDmi;
  end

  assign dr_op        = dr_q[1:0];
  assign dmi_op_valid = update_dr && (dr_sel == SelDmi) && (dr_op == 2'd1 || dr_op == 2'd2);
  assign resp_take    = (dmi_q == DmiWait) && dmi_resp_valid_i;
  assign pending      = (dmi_q != DmiIdle) && !resp_take;
  assign req_accept   = dmi_op_valid && (sticky_q == 2'd0) && !pending;
  assign req_busy     = dmi_op_valid && (sticky_q == 2'd0) && pending;
  assign dtmcs_update = update_dr && (dr_sel == SelDtmcs);
  assign hard_reset   = dtmcs_update && dr_q[17];
  assign err_clear    = dtmcs_update && (dr_q[16] || dr_q[17]);

  // A response landing in the capture cycle is folded into the captured view.
  assign rdata_view  = (resp_take && dmi_req_op_o == 2'd1) ? dmi_resp_data_i : last_rdata_q;
  assign status_view = (sticky_q != 2'd0) ? sticky_q :
                       (resp_take && dmi_resp_err_i != 2'd0) ? 2'd2 :
                       pending ? 2'd3 : 2'd0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dr_q <= '0;
    end else if (capture_dr) begin
      case (dr_sel)
        SelIdcode: dr_q <= DrWidth'(IdCode);
        SelDtmcs:  dr_q <= DrWidth'({14'b0, 3'b0, 3'd1, sticky_q, 6'(DmiAddrWidth), 4'd1});
        SelDmi:    dr_q <= {last_addr_q, rdata_view, status_view};
        default:   dr_q <= '0;
      endcase
    end else if (shift_dr) begin
      case (dr_sel)
        SelDmi:    dr_q <= {tdi_s, dr_q[DrWidth-1:1]};
        SelBypass: dr_q <= {{(DrWidth-1){1'b0}}, tdi_s};
        default:   dr_q <= {{(DrWidth-32){1'b0}}, tdi_s, dr_q[31:1]};
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)         jtag_tdo_o <= 1'b0;
    else if (tck_fall) jtag_tdo_o <= (tap_q == TapShIr) ? ir_shift_q[0] :
                                     (tap_q == TapShDr) ? dr_q[0] : 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) dmi_q <= DmiIdle;
    else       dmi_q <= dmi_d;
  end

  always_comb begin
    dmi_d = dmi_q;
    case (dmi_q)
      DmiIdle: if (req_accept) dmi_d = DmiReq;
      DmiReq: begin
        if (hard_reset)                           dmi_d = DmiIdle;
        else if (dmi_req_ready_i && !drain_q)     dmi_d = DmiWait;
      end
      DmiWait: begin
        if (resp_take)                  dmi_d = req_accept ? DmiReq : DmiIdle;
        else if (hard_reset || timeout) dmi_d = DmiIdle;
      end
      default: dmi_d = DmiIdle;
    endcase
  end

  // While draining an orphaned response the next request is held back.
  always_comb begin
    dmi_req_valid_o  = (dmi_q == DmiReq) && !drain_q;
    dmi_resp_ready_o = (dmi_q == DmiWait) || drain_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      drain_q        <= 1'b0;
      sticky_q       <= 2'd0;
      last_addr_q    <= '0;
      last_rdata_q   <= '0;
      dmi_req_addr_o <= '0;
      dmi_req_data_o <= '0;
      dmi_req_op_o   <= 2'd0;
    end else begin
      if (dmi_q == DmiWait && !dmi_resp_valid_i && (hard_reset || timeout)) drain_q <= 1'b1;
      else if (drain_q && dmi_resp_valid_i)                                drain_q <= 1'b0;
      if (req_accept) begin
        dmi_req_addr_o <= dr_q[DrWidth-1:34];
        dmi_req_data_o <= dr_q[33:2];
        dmi_req_op_o   <= dr_op;
        last_addr_q    <= dr_q[DrWidth-1:34];
      end
      if (resp_take && dmi_req_op_o == 2'd1) last_rdata_q <= dmi_resp_data_i;
      if (tap_q == TapReset || err_clear) sticky_q <= 2'd0;
      if (req_busy) sticky_q <= 2'd3;
      if ((resp_take && dmi_resp_err_i != 2'd0) || timeout) sticky_q <= 2'd2;
    end
  end

`ifdef BGPU_JTAG_DMI_TIMEOUT_EN
  localparam int CntW = $clog2(TimeoutCycles + 1);
  logic [CntW-1:0] wait_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || dmi_q != DmiWait) wait_cnt_q <= '0;
    else                           wait_cnt_q <= wait_cnt_q + CntW'(1);
  end

  assign timeout = (dmi_q == DmiWait) && !dmi_resp_valid_i && (wait_cnt_q == CntW'(TimeoutCycles - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TimeoutCycles;
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_bgpu_jtag_dmi_responder.sv
// tb/tb_bgpu_jtag_dmi_responder.sv - directed JTAG/DMI bench with a transaction-level DTM model
module tb_bgpu_jtag_dmi_responder;
  localparam int HALF = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, tck, tms, tdi, trst_n, tdo;
  logic req_valid, req_ready, resp_valid, resp_ready;
  logic [6:0] req_addr;
  logic [1:0] req_op, resp_err;
  logic [31:0] req_data, resp_data;

  int vectors = 0;
  int errors  = 0;

  logic [4:0]  m_ir;
  logic [1:0]  m_sticky;
  logic [6:0]  m_last_addr, exp_addr;
  logic [31:0] m_last_rdata, exp_data;
  logic [1:0]  exp_op;
  bit exp_req, m_pending, m_drain;

  bgpu_jtag_dmi_responder dut (
    .clk_i(clk), .rst_i(rst),
    .jtag_tck_i(tck), .jtag_tms_i(tms), .jtag_tdi_i(tdi), .jtag_trst_ni(trst_n), .jtag_tdo_o(tdo),
    .dmi_req_valid_o(req_valid), .dmi_req_ready_i(req_ready), .dmi_req_addr_o(req_addr),
    .dmi_req_op_o(req_op), .dmi_req_data_o(req_data),
    .dmi_resp_valid_i(resp_valid), .dmi_resp_ready_o(resp_ready),
    .dmi_resp_data_i(resp_data), .dmi_resp_err_i(resp_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_ir = 5'h01; m_sticky = 2'd0; m_last_addr = '0; m_last_rdata = '0;
    exp_req = 1'b0; m_pending = 1'b0; m_drain = 1'b0;
    exp_addr = '0; exp_data = '0; exp_op = '0;
  endfunction

  function automatic logic [40:0] dmi(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op);
    return {a, d, op};
  endfunction

  function automatic logic [1:0] model_status();
    if (m_sticky != 2'd0) return m_sticky;
    if (exp_req || m_pending) return 2'd3;
    return 2'd0;
  endfunction

  function automatic int model_width();
    case (m_ir)
      5'h01, 5'h10: return 32;
      5'h11:        return 41;
      default:      return 1;
    endcase
  endfunction

  function automatic logic [40:0] model_capture();
    case (m_ir)
      5'h01:   return 41'h0_0000_0DB3;
      5'h10:   return 41'(32'h1071 | (32'(m_sticky) << 10));
      5'h11:   return {m_last_addr, m_last_rdata, model_status()};
      default: return 41'd0;
    endcase
  endfunction

  function automatic void model_update_dr(input logic [40:0] din);
    if (m_ir == 5'h10) begin
      if (din[16] || din[17]) m_sticky = 2'd0;
      if (din[17]) begin
        if (m_pending) m_drain = 1'b1;
        m_pending = 1'b0;
        exp_req = 1'b0;
      end
    end else if (m_ir == 5'h11 && (din[1:0] == 2'd1 || din[1:0] == 2'd2) && m_sticky == 2'd0) begin
      if (exp_req || m_pending) begin
        m_sticky = 2'd3;
      end else begin
        exp_req = 1'b1;
        exp_addr = din[40:34]; exp_data = din[33:2]; exp_op = din[1:0];
        m_last_addr = din[40:34];
      end
    end
  endfunction

  // Every cycle a request is shown, it must be the one the model expects, unchanged.
  always @(negedge clk) begin
    if (!rst && req_valid) begin
      check("req_valid_expected", exp_req, 1'b1);
      check("req_payload", {req_addr, req_data, req_op}, {exp_addr, exp_data, exp_op});
      if (req_ready && exp_req) begin
        exp_req = 1'b0;
        m_pending = 1'b1;
      end
    end
  end

  task automatic jtag_cycle(input logic t_ms, input logic t_di, output logic t_do);
    @(negedge clk);
    tms = t_ms; tdi = t_di;
    repeat (HALF) @(negedge clk);
    t_do = tdo;
    tck = 1'b1;
    repeat (HALF) @(negedge clk);
    tck = 1'b0;
  endtask

  task automatic tap_reset();
    logic b;
    for (int i = 0; i < 5; i++) jtag_cycle(1'b1, 1'b0, b);
    m_ir = 5'h01; m_sticky = 2'd0;
    jtag_cycle(1'b0, 1'b0, b);
  endtask

  task automatic scan_ir(input logic [4:0] code, input string name);
    logic b;
    logic [4:0] out;
    out = '0;
    jtag_cycle(1'b1, 1'b0, b); jtag_cycle(1'b1, 1'b0, b);
    jtag_cycle(1'b0, 1'b0, b); jtag_cycle(1'b0, 1'b0, b);
    for (int i = 0; i < 5; i++) begin
      jtag_cycle(i == 4, code[i], b);
      out[i] = b;
    end
    jtag_cycle(1'b1, 1'b0, b);
    m_ir = code;
    jtag_cycle(1'b0, 1'b0, b);
    check(name, out, 5'b00001);
  endtask

  task automatic scan_dr(input logic [40:0] din, input int n, input string name, output logic [40:0] dout);
    logic b;
    logic [40:0] cap, e;
    int w;
    cap = model_capture();
    w = model_width();
    e = '0; dout = '0;
    for (int i = 0; i < n; i++) begin
      if (i < w) e[i] = cap[i];
      else       e[i] = din[i - w];
    end
    jtag_cycle(1'b1, 1'b0, b); jtag_cycle(1'b0, 1'b0, b); jtag_cycle(1'b0, 1'b0, b);
    for (int i = 0; i < n; i++) begin
      jtag_cycle(i == n - 1, din[i], b);
      dout[i] = b;
    end
    jtag_cycle(1'b1, 1'b0, b);
    model_update_dr(din);
    jtag_cycle(1'b0, 1'b0, b);
    check(name, dout, e);
  endtask

  task automatic wait_handshake(input string name);
    int n = 0;
    while (exp_req && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_req, 1'b0);
  endtask

  task automatic respond(input logic [31:0] d, input logic [1:0] err);
    int n = 0;
    @(negedge clk);
    resp_valid = 1'b1; resp_data = d; resp_err = err;
    while (!resp_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("resp_accepted", n < 100, 1'b1);
    @(negedge clk);
    resp_valid = 1'b0;
    if (m_drain) begin
      m_drain = 1'b0;
    end else begin
      if (exp_op == 2'd1) m_last_rdata = d;
      if (err != 2'd0) m_sticky = 2'd2;
      m_pending = 1'b0;
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [40:0] d;
    logic b;
    rst = 1'b1; tck = 1'b0; tms = 1'b0; tdi = 1'b0; trst_n = 1'b1;
    req_ready = 1'b1; resp_valid = 1'b0; resp_data = '0; resp_err = '0;
    model_reset();
    repeat (4) @(negedge clk);
    check("rst_req_valid", req_valid, 1'b0);
    check("rst_resp_ready", resp_ready, 1'b0);
    check("rst_tdo", tdo, 1'b0);
    check("rst_payload", {req_addr, req_data, req_op}, 41'd0);
    rst = 1'b0;

    jtag_cycle(1'b0, 1'b0, b);
    scan_dr(41'd0, 32, "idcode_default", d);
    check("idcode_literal", d[31:0], 32'h00000DB3);

    tap_reset();
    scan_ir(5'h01, "ir_idcode");
    scan_dr(41'h1_2345_6789, 32, "idcode_scan", d);

    scan_ir(5'h1F, "ir_bypass");
    scan_dr(41'h0A5, 9, "bypass_scan", d);
    check("bypass_delay_literal", d[8:0], {8'hA5, 1'b0});
    scan_ir(5'h07, "ir_unknown");
    scan_dr(41'h05A, 9, "unknown_is_bypass", d);

    scan_ir(5'h10, "ir_dtmcs");
    scan_dr(41'd0, 32, "dtmcs_scan", d);
    check("dtmcs_literal", d[31:0], 32'h00001071);

    scan_ir(5'h11, "ir_dmi");
    req_ready = 1'b0;
    scan_dr(dmi(7'h10, 32'h1, 2'd2), 41, "dmi_write_capture", d);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("req_held_while_not_ready", req_valid, 1'b1);
    end
    check("req_literal", {req_addr, req_data, req_op}, {7'h10, 32'h1, 2'd2});
    req_ready = 1'b1;
    wait_handshake("write_handshake");
    respond(32'h0, 2'd0);
    scan_dr(dmi(7'h0, 32'h0, 2'd0), 41, "after_write", d);

    scan_dr(dmi(7'h11, 32'h0, 2'd1), 41, "dmi_read_issue", d);
    wait_handshake("read_handshake");
    respond(32'hDEADBEEF, 2'd0);
    scan_dr(dmi(7'h0, 32'h0, 2'd0), 41, "after_read", d);
    check("read_literal", d, {7'h11, 32'hDEADBEEF, 2'd0});

    scan_dr(dmi(7'h12, 32'h55, 2'd2), 41, "busy_first", d);
    wait_handshake("busy_handshake");
    scan_dr(dmi(7'h13, 32'h66, 2'd2), 41, "busy_second", d);
    check("pending_status_literal", d[1:0], 2'd3);
    scan_dr(dmi(7'h0, 32'h0, 2'd0), 41, "busy_sticky", d);
    scan_dr(dmi(7'h14, 32'h77, 2'd1), 41, "busy_ignored", d);
    scan_ir(5'h10, "ir_dtmcs_clr");
    scan_dr(41'h0_0001_0000, 32, "dmireset", d);
    check("dtmcs_busy_literal", d[31:0], 32'h00001C71);
    scan_ir(5'h11, "ir_dmi_2");
    scan_dr(dmi(7'h0, 32'h0, 2'd0), 41, "still_pending", d);
    respond(32'h0, 2'd1);
    scan_dr(dmi(7'h0, 32'h0, 2'd0), 41, "err_status", d);
    check("err_status_literal", d[1:0], 2'd2);
    scan_ir(5'h10, "ir_dtmcs_clr2");
    scan_dr(41'h0_0001_0000, 32, "dmireset_err", d);
    check("dtmcs_err_literal", d[31:0], 32'h00001871);
    scan_ir(5'h11, "ir_dmi_3");
    scan_dr(dmi(7'h15, 32'hCAFE, 2'd2), 41, "resume_write", d);
    wait_handshake("resume_handshake");
    respond(32'h0, 2'd0);

    scan_dr(dmi(7'h16, 32'h7, 2'd2), 41, "hardreset_write", d);
    wait_handshake("hardreset_handshake");
    scan_ir(5'h10, "ir_dtmcs_hr");
    scan_dr(41'h0_0002_0000, 32, "dmihardreset", d);
    @(negedge clk);
    check("drain_ready_high", resp_ready, 1'b1);
    respond(32'hBAD, 2'd2);
    scan_ir(5'h11, "ir_dmi_4");
    scan_dr(dmi(7'h0, 32'h0, 2'd0), 41, "after_drain", d);
    check("after_drain_literal", d, {7'h16, 32'hDEADBEEF, 2'd0});

    scan_dr(dmi(7'h17, 32'h0, 2'd1), 41, "rst_read", d);
    wait_handshake("rst_handshake");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_valid", req_valid, 1'b0);
    check("rst_mid_ready", resp_ready, 1'b0);
    rst = 1'b0;
    model_reset();
    jtag_cycle(1'b0, 1'b0, b);
    scan_dr(41'd0, 32, "idcode_after_rst", d);

    scan_ir(5'h10, "ir_dtmcs_tlr");
    jtag_cycle(1'b1, 1'b0, b); jtag_cycle(1'b0, 1'b0, b); jtag_cycle(1'b0, 1'b0, b);
    for (int i = 0; i < 5; i++) jtag_cycle(1'b1, 1'b0, b);
    m_ir = 5'h01; m_sticky = 2'd0;
    jtag_cycle(1'b0, 1'b0, b);
    scan_dr(41'd0, 32, "idcode_after_tms_reset", d);
    check("tms_reset_literal", d[31:0], 32'h00000DB3);

`ifdef BGPU_JTAG_DMI_TIMEOUT_EN
    scan_ir(5'h11, "ir_dmi_to");
    scan_dr(dmi(7'h18, 32'h9, 2'd2), 41, "timeout_write", d);
    wait_handshake("timeout_handshake");
    repeat (1100) @(negedge clk);
    m_sticky = 2'd2; m_pending = 1'b0; m_drain = 1'b1;
    check("timeout_ready_high", resp_ready, 1'b1);
    check("timeout_valid_low", req_valid, 1'b0);
    scan_dr(dmi(7'h0, 32'h0, 2'd0), 41, "timeout_status", d);
    check("timeout_status_literal", d[1:0], 2'd2);
    respond(32'h1234, 2'd0);
`endif

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
